// File: rtl/rpn_sequencer_pkg.sv
// ============================================================================
// Module      : rpn_pkg
// Description : Shared types and constants for the RPN calculator sequencer.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rpn_pkg;

    localparam int INSTR_W = 18;
    localparam logic [9:0] STACK_MAX = 10'd1023;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_NEG  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    localparam logic [1:0] K_PUSH = 2'b00;
    localparam logic [1:0] K_OP   = 2'b01;
    localparam logic [1:0] K_HALT = 2'b10;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_BAD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FETCH  = 3'd2,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4,
        S_HOLD   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rpn_sequencer_if.sv
// ============================================================================
// Module      : rpn_sequencer_if
// Description : Command/status bundle between the sequencer and the calculator.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface rpn_sequencer_if;
    logic               calc_nrst;
    logic               calc_step;
    logic               calc_push;
    logic signed [15:0] calc_d;
    logic [1:0]         calc_op;
    logic signed [15:0] calc_out;
    logic [9:0]         calc_cnt;

    modport master (
        output calc_nrst, calc_step, calc_push, calc_d, calc_op,
        input  calc_out, calc_cnt
    );

    modport slave (
        input  calc_nrst, calc_step, calc_push, calc_d, calc_op,
        output calc_out, calc_cnt
    );
endinterface

`default_nettype wire

// File: rtl/rpn_sequencer_prog_mem.sv
// ============================================================================
// Module      : rpn_prog_mem
// Description : Instruction store, one write port, synchronous read, no reset.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rpn_prog_mem
    import rpn_pkg::*;
#(
    parameter int PROG_DEPTH = 64,
    parameter int PC_W       = $clog2(PROG_DEPTH)
) (
    input  wire logic               clk,
    input  wire logic               we,
    input  wire logic [PC_W-1:0]    waddr,
    input  wire logic [INSTR_W-1:0] wdata,
    input  wire logic [PC_W-1:0]    raddr,
    output logic      [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] r_mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end

endmodule

`default_nettype wire

// File: rtl/rpn_sequencer.sv
// ============================================================================
// Module      : rpn_sequencer
// Description : Replays a stored program into the RPN calculator as push/op steps.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int PROG_DEPTH = 64,
    parameter int PC_W       = $clog2(PROG_DEPTH)
) (
    input  wire logic               clk,
    input  wire logic               nrst,
    input  wire logic               prog_we,
    input  wire logic [PC_W-1:0]    prog_addr,
    input  wire logic [INSTR_W-1:0] prog_data,
    input  wire logic               start,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err,
    output logic signed [15:0]      result,
    rpn_sequencer_if.master         calc
);

    state_t             r_state;
    state_t             w_next;
    logic [PC_W-1:0]    r_pc;
    logic [1:0]         r_err;
    logic signed [15:0] r_result;
    logic               r_step;

    logic               w_err_load;
    logic [1:0]         w_err_code;
    logic               w_res_load;
    logic               w_launch;
    logic               w_drive;

    logic [INSTR_W-1:0] w_word;
    logic [1:0]         w_kind;
    logic [1:0]         w_op;
    logic [9:0]         w_need;

    rpn_prog_mem #(
        .PROG_DEPTH (PROG_DEPTH),
        .PC_W       (PC_W)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && (r_state == S_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (r_pc),
        .rdata (w_word)
    );

    assign w_kind   = w_word[17:16];
    assign w_op     = w_word[1:0];
    assign w_need   = ((w_op == OP_ADD) || (w_op == OP_MUL)) ? 10'd2 : 10'd1;
    assign w_launch = (r_state == S_IDLE) && start;

    always_comb begin
        w_next     = r_state;
        w_err_load = 1'b0;
        w_err_code = ERR_OK;
        w_res_load = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLEAR;
            S_CLEAR:  w_next = S_FETCH;
            S_FETCH:  w_next = S_SETUP;
            S_SETUP: begin
                case (w_kind)
                    K_PUSH: begin
                        if (calc.calc_cnt == STACK_MAX) begin
                            w_err_load = 1'b1;
                            w_err_code = ERR_OVER;
                            w_next     = S_DONE;
                        end else begin
                            w_next = S_STROBE;
                        end
                    end
                    K_OP: begin
                        if (calc.calc_cnt < w_need) begin
                            w_err_load = 1'b1;
                            w_err_code = ERR_UNDER;
                            w_next     = S_DONE;
                        end else begin
                            w_next = S_STROBE;
                        end
                    end
                    K_HALT: begin
                        w_res_load = 1'b1;
                        w_next     = S_DONE;
                    end
                    default: begin
                        w_err_load = 1'b1;
                        w_err_code = ERR_BAD;
                        w_next     = S_DONE;
                    end
                endcase
            end
            S_STROBE: w_next = S_HOLD;
            S_HOLD: begin
                // Walking off the end of memory means the program never halted
                if (r_pc == PC_W'(PROG_DEPTH - 1)) begin
                    w_err_load = 1'b1;
                    w_err_code = ERR_BAD;
                    w_next     = S_DONE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_err    <= ERR_OK;
            r_result <= '0;
            r_step   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_step  <= (w_next == S_STROBE);
            if (w_launch) begin
                r_pc <= '0;
            end else if (r_state == S_HOLD) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_launch) begin
                r_err <= ERR_OK;
            end else if (w_err_load) begin
                r_err <= w_err_code;
            end
            if (w_launch) begin
                r_result <= '0;
            end else if (w_res_load) begin
                r_result <= calc.calc_out;
            end
        end
    end

    // Read data stays stable from SETUP through HOLD because pc only moves at the end of HOLD
    assign w_drive = ((r_state == S_SETUP) && (w_next == S_STROBE)) ||
                     (r_state == S_STROBE) || (r_state == S_HOLD);

    assign calc.calc_nrst = nrst && (r_state != S_CLEAR);
    assign calc.calc_step = r_step;
    assign calc.calc_push = w_drive && (w_kind == K_PUSH);
    assign calc.calc_d    = (w_drive && (w_kind == K_PUSH)) ? $signed(w_word[15:0]) : 16'sd0;
    assign calc.calc_op   = (w_drive && (w_kind == K_OP)) ? w_op : OP_NONE;

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign err    = r_err;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_rpn_sequencer.sv
// ============================================================================
// Module      : tb_rpn_sequencer
// Description : Directed bench for rpn_sequencer with a behavioural calculator.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rpn_sequencer;
    import rpn_pkg::*;

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic               prog_we = 1'b0;
    logic [5:0]         prog_addr = '0;
    logic [17:0]        prog_data = '0;
    logic               start = 1'b0;
    logic               busy;
    logic               done;
    logic [1:0]         err;
    logic signed [15:0] result;

    rpn_sequencer_if cif();

    rpn_sequencer #(.PROG_DEPTH(64)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .calc      (cif.master)
    );

    always #5 clk = ~clk;

    // Behavioural calculator
    logic signed [15:0] stk [1024];
    int                 depth;
    logic               force_full = 1'b0;

    always @(posedge clk or negedge cif.calc_nrst) begin
        if (!cif.calc_nrst) begin
            depth <= 0;
        end else if (cif.calc_step) begin
            if (cif.calc_push) begin
                stk[depth] <= cif.calc_d;
                depth      <= depth + 1;
            end else begin
                case (cif.calc_op)
                    OP_NEG: stk[depth-1] <= -stk[depth-1];
                    OP_ADD: begin
                        stk[depth-2] <= stk[depth-2] + stk[depth-1];
                        depth        <= depth - 1;
                    end
                    OP_MUL: begin
                        stk[depth-2] <= stk[depth-2] * stk[depth-1];
                        depth        <= depth - 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cif.calc_out = (depth > 0) ? stk[depth-1] : 16'sd0;
    assign cif.calc_cnt = force_full ? 10'd1023 : depth[9:0];

    int steps = 0;
    always @(posedge clk) if (cif.calc_step) steps <= steps + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] w_push(input logic [15:0] v);
        return {K_PUSH, v};
    endfunction
    function automatic logic [17:0] w_opc(input logic [1:0] o);
        return {K_OP, 14'd0, o};
    endfunction
    function automatic logic [17:0] w_halt();
        return {K_HALT, 16'd0};
    endfunction

    task automatic wr(input int a, input logic [17:0] w);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a[5:0];
        prog_data = w;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    // Pulses start and waits for done; dcyc counts from the start-sampling edge as cycle 0
    task automatic run(output int dcyc, output int nsteps, output logic busy1);
        int s0;
        s0 = steps;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy1 = busy;
        dcyc  = -1;
        for (int c = 1; c < 400; c++) begin
            if (done) begin
                dcyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        nsteps = steps - s0;
        @(posedge clk);
        #1;
    endtask

    int   dc, ns, cnt2;
    logic b1;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_err",   {30'd0, err}, 32'd0);
        chk("rst_res",   {16'd0, result}, 32'd0);
        chk("rst_step",  {31'd0, cif.calc_step}, 32'd0);
        chk("rst_push",  {31'd0, cif.calc_push}, 32'd0);
        chk("rst_d",     {16'd0, cif.calc_d}, 32'd0);
        chk("rst_op",    {30'd0, cif.calc_op}, 32'd0);
        chk("rst_cnrst", {31'd0, cif.calc_nrst}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // 3 + 4
        wr(0, w_push(16'd3)); wr(1, w_push(16'd4)); wr(2, w_opc(OP_ADD)); wr(3, w_halt());
        run(dc, ns, b1);
        chk("t1_busy",  {31'd0, b1}, 32'd1);
        chk("t1_cyc",   dc, 32'd16);
        chk("t1_res",   {16'd0, result}, 32'd7);
        chk("t1_err",   {30'd0, err}, 32'd0);
        chk("t1_cnt",   {22'd0, cif.calc_cnt}, 32'd1);
        chk("t1_steps", ns, 32'd3);
        chk("t1_idle",  {31'd0, busy}, 32'd0);

        // -5 * -2
        wr(0, w_push(16'd5)); wr(1, w_opc(OP_NEG)); wr(2, w_push(16'hFFFE));
        wr(3, w_opc(OP_MUL)); wr(4, w_halt());
        run(dc, ns, b1);
        chk("t2_cyc", dc, 32'd20);
        chk("t2_res", {16'd0, result}, 32'd10);
        chk("t2_err", {30'd0, err}, 32'd0);
        chk("t2_cnt", {22'd0, cif.calc_cnt}, 32'd1);

        // Underflow on first instruction
        wr(0, w_opc(OP_ADD));
        run(dc, ns, b1);
        chk("t3_err",   {30'd0, err}, 32'd1);
        chk("t3_res",   {16'd0, result}, 32'd0);
        chk("t3_cyc",   dc, 32'd4);
        chk("t3_steps", ns, 32'd0);

        // Overflow with a forced-full stack
        force_full = 1'b1;
        wr(0, w_push(16'd1)); wr(1, w_halt());
        run(dc, ns, b1);
        chk("t4_err",   {30'd0, err}, 32'd2);
        chk("t4_steps", ns, 32'd0);
        chk("t4_cyc",   dc, 32'd4);
        force_full = 1'b0;

        // Runaway program
        for (int a = 0; a < 64; a++) wr(a, w_push(16'd0));
        run(dc, ns, b1);
        chk("t5_err",   {30'd0, err}, 32'd3);
        chk("t5_steps", ns, 32'd64);
        chk("t5_cyc",   dc, 32'd258);
        chk("t5_cnt",   {22'd0, cif.calc_cnt}, 32'd64);

        // Wrapping multiply
        wr(0, w_push(16'h7FFF)); wr(1, w_push(16'd2)); wr(2, w_opc(OP_MUL)); wr(3, w_halt());
        run(dc, ns, b1);
        chk("t6_res", {16'd0, result}, 32'h0000FFFE);
        chk("t6_err", {30'd0, err}, 32'd0);
        chk("t6_cyc", dc, 32'd16);

        // Reserved kind at address 1
        wr(0, w_push(16'd1)); wr(1, 18'h3_0000);
        run(dc, ns, b1);
        chk("t7_err",   {30'd0, err}, 32'd3);
        chk("t7_steps", ns, 32'd1);
        chk("t7_cyc",   dc, 32'd8);
        chk("t7_res",   {16'd0, result}, 32'd0);

        // Reset during the second strobe
        wr(0, w_push(16'd3)); wr(1, w_push(16'd4)); wr(2, w_opc(OP_ADD)); wr(3, w_halt());
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt2 = 0;
        for (int c = 1; c < 60; c++) begin
            if (cif.calc_step) cnt2++;
            if (cnt2 == 2) break;
            @(posedge clk);
            #1;
        end
        chk("t8_reach", cnt2, 32'd2);
        #1 nrst = 1'b0;
        #1;
        chk("t8_step",  {31'd0, cif.calc_step}, 32'd0);
        chk("t8_busy",  {31'd0, busy}, 32'd0);
        chk("t8_done",  {31'd0, done}, 32'd0);
        chk("t8_push",  {31'd0, cif.calc_push}, 32'd0);
        chk("t8_d",     {16'd0, cif.calc_d}, 32'd0);
        chk("t8_op",    {30'd0, cif.calc_op}, 32'd0);
        chk("t8_err",   {30'd0, err}, 32'd0);
        chk("t8_res",   {16'd0, result}, 32'd0);
        chk("t8_cnrst", {31'd0, cif.calc_nrst}, 32'd0);
        chk("t8_cnt",   {22'd0, cif.calc_cnt}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Re-run with a write and a start injected while busy
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc = -1;
        for (int c = 1; c < 100; c++) begin
            if (c == 5) begin prog_we = 1'b1; prog_addr = 6'd2; prog_data = w_opc(OP_MUL); end
            if (c == 6) prog_we = 1'b0;
            if (c == 7) start = 1'b1;
            if (c == 8) start = 1'b0;
            if (done) begin dc = c; break; end
            @(posedge clk);
            #1;
        end
        chk("t9_cyc", dc, 32'd16);
        chk("t9_res", {16'd0, result}, 32'd7);
        chk("t9_err", {30'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        chk("t9_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/rpn_sequencer.md
# rpn_sequencer

Program-driven initiator for the 16-bit RPN stack calculator (ops NONE/NEG/ADD/MUL, push/step/op interface, 10-bit depth counter). It holds a small loadable instruction memory and, on `start`, clears the calculator and replays the program as push/op commands. Each command is issued with a single pulse on the calculator's `step` strobe. Before each step it checks stack depth, then captures the final top-of-stack as `result`. It sits between a host/test harness and the calculator, replacing hand-toggled stimulus.

## Interface
- `PROG_DEPTH`, 64, number of instruction words (power of two).
- `PC_W`, $clog2(PROG_DEPTH), program-counter / write-address width.
- `clk` input 1: clock.
- `nrst` input 1: reset, asynchronous, active-low.
- `prog_we` input 1: write strobe for the instruction memory. Ignored while `busy`.
- `prog_addr` input PC_W: write address.
- `prog_data` input 18: instruction word. [17:16] is the kind; [15:0] is the payload.
- `start` input 1: begin execution at address 0. Sampled only in IDLE.
- `busy` output 1: high from the cycle after `start` until DONE exits.
- `done` output 1: one-cycle pulse at end of run, on success or error.
- `err` output 2: 00 ok, 01 underflow, 10 overflow, 11 bad kind/runaway. Held until next `start`.
- `result` output 16 signed: captured `calc_out`. Held until next `start`.
- `calc_nrst` output 1: calculator reset, equal to `nrst` AND (state != CLEAR).
- `calc_step` output 1: calculator strobe, registered, high only in STROBE.
- `calc_push` output 1: calculator push.
- `calc_d` output 16 signed: push operand.
- `calc_op` output 2: calculator op.
- `calc_out` input 16 signed: calculator top of stack.
- `calc_cnt` input 10: calculator depth.

## Operation
- Instruction kinds:
  - 00 PUSH: push payload[15:0].
  - 01 OP: payload[1:0] is the op, 00 NONE, 01 NEG, 10 ADD, 11 MUL.
  - 10 HALT.
  - 11 reserved, which is an error.
- States: IDLE, CLEAR, FETCH, SETUP, STROBE, HOLD, DONE.
- IDLE: `start` → CLEAR. At the same time: `err`<=00, `result`<=0, `pc`<=0.
- CLEAR, 1 cycle: `calc_nrst`=0 empties the calculator. Then → FETCH.
- FETCH: memory address = `pc`. The memory has synchronous read, so data is valid in SETUP.
- SETUP: decode the word and check `calc_cnt`.
  - PUSH with `calc_cnt`==1023 → err 10, go to DONE.
  - NONE/NEG with `calc_cnt`<1 → err 01, go to DONE.
  - ADD/MUL with `calc_cnt`<2 → err 01, go to DONE.
  - kind 11 → err 11, go to DONE.
  - HALT → DONE, with `result`<=`calc_out`.
  - Otherwise drive `calc_push`/`calc_d`/`calc_op` and go to STROBE.
- PUSH drives `calc_op`=00 and `calc_push`=1. OP drives `calc_push`=0 and `calc_d`=0.
- STROBE: `calc_step`=1; the calculator commits on this rising edge. Controls are held.
- HOLD: `calc_step`=0, controls held, `pc`<=`pc`+1. If `pc`==PROG_DEPTH-1, no HALT was reached → err 11, go to DONE. Otherwise → FETCH.
- DONE, 1 cycle: `done`=1. Then → IDLE.
- An error aborts without issuing the offending step. The calculator keeps its pre-error stack.
- Arithmetic belongs to the calculator. `result` is its 16-bit two's-complement top, wrapped.
- `prog_we` in IDLE writes `mem[prog_addr]`. Writes during `busy` are dropped.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `calc_step`, `calc_push` = 0.
  - `calc_d` = 0, `calc_op` = 00.
  - `err` = 00, `result` = 0.
  - `calc_nrst` = 0 while `nrst` is low.
- Let the `start` sample edge be cycle 0. CLEAR is cycle 1 and the first FETCH is cycle 2.
- Each PUSH/OP takes 4 cycles: FETCH, SETUP, STROBE, HOLD.
- HALT takes 2 cycles. `done` is high in cycle 2+4N+2 for N non-HALT instructions.
- Setup/hold to the calculator: `calc_d`, `calc_op` and `calc_push` are stable from SETUP through HOLD, which is one cycle on each side of the `calc_step` rise.
- `calc_cnt` is sampled in SETUP, a full cycle after the previous HOLD, so it is settled.
- `start` while `busy` is ignored. `start` asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.
- Reset mid-run, in any state:
  - Immediate return to reset values. `calc_step` drops at once.
  - `calc_nrst` follows `nrst` low, so the calculator clears too.
  - Instruction memory contents are retained.

## Structure
- Package `rpn_pkg`:
  - op constants OP_NONE/OP_NEG/OP_ADD/OP_MUL.
  - kind constants K_PUSH/K_OP/K_HALT.
  - state enum.
  - err codes ERR_OK/ERR_UNDER/ERR_OVER/ERR_BAD.
  - INSTR_W=18, STACK_MAX=1023.
- Sub-module `rpn_prog_mem`: PROG_DEPTH×18 synchronous-read, single-write-port array, no reset on contents.
- FSM, checks and output registers live in `rpn_sequencer`.

## Test plan
- PUSH 3, PUSH 4, ADD, HALT → `done` in cycle 16, `result`=7, `err`=00, `calc_cnt`=1, exactly 3 `calc_step` pulses.
- PUSH 5, NEG, PUSH 0xFFFE, MUL, HALT → `result`=10, `err`=00, `calc_cnt`=1.
- ADD at address 0 → `err`=01, `result`=0, `done` in cycle 4, zero `calc_step` pulses.
- Bench model forces `calc_cnt`=1023, then PUSH 1 → `err`=10, no step. Program with no HALT, all PUSH 0 → `err`=11 after PROG_DEPTH steps.
- PUSH 0x7FFF, PUSH 2, MUL, HALT → `result`=0xFFFE (wrap), `err`=00. Reserved kind 11 at address 1 → `err`=11 after one step.
- `nrst` pulsed low during the 2nd STROBE → all outputs at reset values and `calc_nrst`=0. A re-`start` then gives the correct result; `start` and `prog_we` while busy have no effect.
